// File: rtl/axis_pkt_arbiter.sv
// Packet-granular 2:1 AXI4-Stream arbiter (round-robin or fixed priority) feeding one AXIS slave.
// Optional statistics counters are enabled with the AXIS_ARB_STATS_EN macro.
module axis_pkt_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned USER_W = 128
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                cfg_fixed_pri,

    input  logic [DATA_W-1:0]   S0_AXIS_DAT_TDATA,
    input  logic [DATA_W/8-1:0] S0_AXIS_DAT_TSTRB,
    input  logic [USER_W-1:0]   S0_AXIS_DAT_TUSER,
    input  logic                S0_AXIS_DAT_TLAST,
    input  logic                S0_AXIS_DAT_TVALID,
    output logic                S0_AXIS_DAT_TREADY,

    input  logic [DATA_W-1:0]   S1_AXIS_DAT_TDATA,
    input  logic [DATA_W/8-1:0] S1_AXIS_DAT_TSTRB,
    input  logic [USER_W-1:0]   S1_AXIS_DAT_TUSER,
    input  logic                S1_AXIS_DAT_TLAST,
    input  logic                S1_AXIS_DAT_TVALID,
    output logic                S1_AXIS_DAT_TREADY,

    output logic [DATA_W-1:0]   M_AXIS_DAT_TDATA,
    output logic [DATA_W/8-1:0] M_AXIS_DAT_TSTRB,
    output logic [USER_W-1:0]   M_AXIS_DAT_TUSER,
    output logic                M_AXIS_DAT_TLAST,
    output logic                M_AXIS_DAT_TVALID,
    input  logic                M_AXIS_DAT_TREADY,

    output logic [1:0]          grant
`ifdef AXIS_ARB_STATS_EN
    ,
    output logic [15:0]         pkt_cnt0,
    output logic [15:0]         pkt_cnt1,
    output logic [31:0]         stall_cnt
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY0 = 2'd1;
    localparam logic [1:0] BUSY1 = 2'd2;

    logic [1:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                // Round-robin favours the input that did not finish the previous packet
                if (S0_AXIS_DAT_TVALID && S1_AXIS_DAT_TVALID) begin
                    state_d = (cfg_fixed_pri || last_grant_q) ? BUSY0 : BUSY1;
                end else if (S0_AXIS_DAT_TVALID) begin
                    state_d = BUSY0;
                end else if (S1_AXIS_DAT_TVALID) begin
                    state_d = BUSY1;
                end
            end
            BUSY0: begin
                if (S0_AXIS_DAT_TVALID && M_AXIS_DAT_TREADY && S0_AXIS_DAT_TLAST) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b0;
                end
            end
            BUSY1: begin
                if (S1_AXIS_DAT_TVALID && M_AXIS_DAT_TREADY && S1_AXIS_DAT_TLAST) begin
                    state_d      = IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        M_AXIS_DAT_TDATA   = '0;
        M_AXIS_DAT_TSTRB   = '0;
        M_AXIS_DAT_TUSER   = '0;
        M_AXIS_DAT_TLAST   = 1'b0;
        M_AXIS_DAT_TVALID  = 1'b0;
        S0_AXIS_DAT_TREADY = 1'b0;
        S1_AXIS_DAT_TREADY = 1'b0;
        grant              = 2'b00;
        case (state_q)
            BUSY0: begin
                M_AXIS_DAT_TDATA   = S0_AXIS_DAT_TDATA;
                M_AXIS_DAT_TSTRB   = S0_AXIS_DAT_TSTRB;
                M_AXIS_DAT_TUSER   = S0_AXIS_DAT_TUSER;
                M_AXIS_DAT_TLAST   = S0_AXIS_DAT_TLAST;
                M_AXIS_DAT_TVALID  = S0_AXIS_DAT_TVALID;
                S0_AXIS_DAT_TREADY = M_AXIS_DAT_TREADY;
                grant              = 2'b01;
            end
            BUSY1: begin
                M_AXIS_DAT_TDATA   = S1_AXIS_DAT_TDATA;
                M_AXIS_DAT_TSTRB   = S1_AXIS_DAT_TSTRB;
                M_AXIS_DAT_TUSER   = S1_AXIS_DAT_TUSER;
                M_AXIS_DAT_TLAST   = S1_AXIS_DAT_TLAST;
                M_AXIS_DAT_TVALID  = S1_AXIS_DAT_TVALID;
                S1_AXIS_DAT_TREADY = M_AXIS_DAT_TREADY;
                grant              = 2'b10;
            end
            default: ;
        endcase
    end

`ifdef AXIS_ARB_STATS_EN
    logic [15:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [15:0] pkt_cnt1_q, pkt_cnt1_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        eop0, eop1, stalled;

    assign eop0 = (state_q == BUSY0) && S0_AXIS_DAT_TVALID && M_AXIS_DAT_TREADY
                  && S0_AXIS_DAT_TLAST;
    assign eop1 = (state_q == BUSY1) && S1_AXIS_DAT_TVALID && M_AXIS_DAT_TREADY
                  && S1_AXIS_DAT_TLAST;
    assign stalled = !M_AXIS_DAT_TREADY &&
                     (((state_q == BUSY0) && S0_AXIS_DAT_TVALID) ||
                      ((state_q == BUSY1) && S1_AXIS_DAT_TVALID));

    // Packet counters saturate; the stall counter is allowed to wrap
    always_comb begin
        pkt_cnt0_d  = pkt_cnt0_q;
        pkt_cnt1_d  = pkt_cnt1_q;
        stall_cnt_d = stall_cnt_q;
        if (eop0 && (pkt_cnt0_q != 16'hFFFF)) pkt_cnt0_d = pkt_cnt0_q + 16'd1;
        if (eop1 && (pkt_cnt1_q != 16'hFFFF)) pkt_cnt1_d = pkt_cnt1_q + 16'd1;
        if (stalled) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pkt_cnt0_q  <= '0;
            pkt_cnt1_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            pkt_cnt0_q  <= pkt_cnt0_d;
            pkt_cnt1_q  <= pkt_cnt1_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pkt_cnt0  = pkt_cnt0_q;
    assign pkt_cnt1  = pkt_cnt1_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule
